// File: rtl/imem_loader.sv
// imem_loader: writer side of the CPU instruction RAM.
// Receives a byte stream (valid/ready), assembles little-endian 32-bit words,
// drives one RAM write port and holds the CPU in reset until a complete frame
// has been loaded.
// Frame: CNT_LO, CNT_HI (word count N), 4*N data bytes, [checksum byte].
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR-of-data-bytes checksum before the CPU is released.
module imem_loader #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Word index is one bit wider than a 16-bit count so N == 2**ADDR_W fits.
  localparam int unsigned IDX_W     = 17;
  localparam logic [IDX_W-1:0] MAX_WORDS = 17'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK, S_FINISH, S_ERROR
  } state_t;
  localparam state_t S_TAIL = S_CHECK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_FINISH, S_ERROR
  } state_t;
  localparam state_t S_TAIL = S_FINISH;
`endif

  state_t state, state_nxt;

  logic [15:0]      count;
  logic [15:0]      cnt_full;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      wbuf;
  logic             xfer;
  logic             last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       cksum;
`endif

  assign xfer      = in_valid && in_ready;
  // Count decision in CNT_HI uses the byte being transferred, not the register.
  assign cnt_full  = {in_data, count[7:0]};
  assign last_word = (word_idx + 17'd1) == {1'b0, count};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CNT_LO;
      end
      S_CNT_LO: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = S_CNT_HI;
      end
      S_CNT_HI: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (cnt_full == 16'd0)                   state_nxt = S_TAIL;
          else if ({1'b0, cnt_full} > MAX_WORDS)   state_nxt = S_ERROR;
          else                                     state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (xfer && byte_idx == 2'd3 && last_word) state_nxt = S_TAIL;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = (in_data == cksum) ? S_FINISH : S_ERROR;
      end
`endif
      S_FINISH: state_nxt = S_IDLE;
      S_ERROR:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: count capture, word assembly, RAM write pulse and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      wbuf      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cksum     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            word_idx  <= '0;
            byte_idx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum     <= '0;
`endif
          end
        end
        S_CNT_LO: begin
          if (xfer) count[7:0] <= in_data;
        end
        S_CNT_HI: begin
          if (xfer) begin
            count[15:8] <= in_data;
            byte_idx    <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum    <= cksum ^ in_data;
`endif
            case (byte_idx)
              2'd0: wbuf[7:0]   <= in_data;
              2'd1: wbuf[15:8]  <= in_data;
              2'd2: wbuf[23:16] <= in_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= word_idx[ADDR_W-1:0];
                mem_wdata <= {in_data, wbuf};
                word_idx  <= word_idx + 17'd1;
              end
            endcase
          end
        end
        S_FINISH: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cpu_rst_n <= 1'b1;
        end
        S_ERROR: begin
          error     <= 1'b1;
          busy      <= 1'b0;
          cpu_rst_n <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames against a word-level model.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]  fq [$];   // frame bytes to send
  logic [31:0] wq [$];   // words carried by the frame
  int          eq_cyc  [$];
  int          eq_addr [$];
  logic [31:0] eq_data [$];
  logic [31:0] tb_ram  [0:DEPTH-1];
  logic [31:0] exp_ram [0:DEPTH-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM-side monitor: every write must match the next expected write and cycle.
  logic prev_we = 1'b0;
  int   m_cyc, m_addr;
  logic [31:0] m_data;
  always @(negedge clk) begin
    if (!rst_n) prev_we = 1'b0;
    else begin
      if (mem_we) begin
        check("we_single", {31'd0, prev_we}, 32'd0);
        if (eq_cyc.size() == 0) check("we_unexpected", 32'd1, 32'd0);
        else begin
          m_cyc  = eq_cyc.pop_front();
          m_addr = eq_addr.pop_front();
          m_data = eq_data.pop_front();
          check("we_cycle", cyc, m_cyc);
          check("we_addr", {20'd0, mem_addr}, m_addr);
          check("we_data", mem_wdata, m_data);
        end
        tb_ram[mem_addr] = mem_wdata;
      end
      prev_we = mem_we;
    end
  end

  // Build a frame from wq: count, little-endian words, optional checksum.
  task automatic build_frame(input bit bad_ck);
    logic [7:0] x;
    logic [15:0] n;
    x = 8'h00;
    n = 16'(wq.size());
    fq.delete();
    fq.push_back(n[7:0]);
    fq.push_back(n[15:8]);
    foreach (wq[i]) begin
      for (int b = 0; b < 4; b++) begin
        fq.push_back(8'((wq[i] >> (8 * b)) & 32'hFF));
        x = x ^ 8'((wq[i] >> (8 * b)) & 32'hFF);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    fq.push_back(bad_ck ? (x ^ 8'h01) : x);
`else
    if (bad_ck) x = 8'h00;
`endif
  endtask

  task automatic rand_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_error", {31'd0, error}, 32'd0);
  endtask

  // Push bytes through the handshake; register the expected write when a
  // word's fourth byte is accepted.
  task automatic send_frame(input bit rnd, input int limit);
    int n, nw, guard, gap, w;
    bit acc;
    n  = (limit < fq.size()) ? limit : fq.size();
    nw = wq.size();
    for (int p = 0; p < n; p++) begin
      if (rnd) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = fq[p];
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        @(negedge clk);
        acc = in_ready;
        if (acc && p >= 2 && p < 2 + 4 * nw && ((p - 2) % 4) == 3) begin
          w = (p - 2) / 4;
          eq_cyc.push_back(cyc + 1);
          eq_addr.push_back(w);
          eq_data.push_back(wq[w]);
          exp_ram[w] = wq[w];
        end
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) check("hs_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic finish_wait(input bit e_done, input bit e_err);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("busy_drop", {31'd0, busy}, 32'd0);
    check("done", {31'd0, done}, {31'd0, e_done});
    check("error", {31'd0, error}, {31'd0, e_err});
    check("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, e_done});
    check("writes_pending", eq_cyc.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic full_frame(input bit rnd, input bit bad_ck, input bit e_ok);
    build_frame(bad_ck);
    pulse_start();
    send_frame(rnd, fq.size());
    finish_wait(e_ok, !e_ok);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    reset_vals("rst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Bytes offered while idle must not be accepted.
    in_valid = 1'b1; in_data = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Reference two-word program, full rate then with gaps.
    wq.delete(); wq.push_back(32'h00000013); wq.push_back(32'h00100093);
    full_frame(1'b0, 1'b0, 1'b1);
    check("ram0", tb_ram[0], 32'h00000013);
    check("ram1", tb_ram[1], 32'h00100093);
    full_frame(1'b1, 1'b0, 1'b1);
    check("ram0_rnd", tb_ram[0], 32'h00000013);
    check("ram1_rnd", tb_ram[1], 32'h00100093);

    // Count one above capacity aborts with no writes.
    wq.delete();
    fq.delete(); fq.push_back(8'h01); fq.push_back(8'h10);
    pulse_start();
    send_frame(1'b0, 2);
    finish_wait(1'b0, 1'b1);

    // Recovery after an abort.
    rand_words(3);
    full_frame(1'b1, 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: words still land but the load is rejected.
    wq.delete(); wq.push_back(32'h00000013); wq.push_back(32'h00100093);
    full_frame(1'b0, 1'b1, 1'b0);
    check("bad_ck_ram1", tb_ram[1], 32'h00100093);
`endif

    // Empty program.
    wq.delete();
    full_frame(1'b1, 1'b0, 1'b1);

    // Random programs.
    for (int k = 0; k < 4; k++) begin
      rand_words($urandom_range(1, 6));
      full_frame(1'b1, 1'b0, 1'b1);
      for (int a = 0; a < wq.size(); a++) check("rand_ram", tb_ram[a], exp_ram[a]);
    end

    // Asynchronous reset after six data bytes.
    rand_words(3);
    build_frame(1'b0);
    pulse_start();
    send_frame(1'b0, 8);
    rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    eq_cyc.delete(); eq_addr.delete(); eq_data.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rand_words(2);
    full_frame(1'b0, 1'b0, 1'b1);
    check("reload_ram0", tb_ram[0], wq[0]);
    check("reload_ram1", tb_ram[1], wq[1]);

    // Full-depth program: last word lands at the top address.
    rand_words(DEPTH);
    full_frame(1'b0, 1'b0, 1'b1);
    check("full_ram_top", tb_ram[DEPTH-1], wq[DEPTH-1]);
    check("full_ram_mid", tb_ram[DEPTH/2], wq[DEPTH/2]);
    check("full_ram_bot", tb_ram[0], wq[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
